bti_tcm: RTL and testbench

BTI_TCM -- requirements
Module: bti_tcm

---
 rtl/bti_pkg.sv | 28 ++
 rtl/bti_tcm_if.sv | 20 ++
 rtl/bti_rsp_fifo.sv | 59 +++++
 rtl/bti_tcm.sv | 109 ++++++++++
 tb/tb_bti_tcm.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bti_pkg.sv
// rtl/bti_pkg.sv - shared BTI command and packet types
// Purpose: command encoding, transaction id width and request/response
// packet layouts shared by every BTI agent.
package bti_pkg;

  localparam int BTI_TIDW = 4;

  // Encodings outside this enum are treated as unknown commands.
  typedef enum logic [1:0] {
    BTI_CMD_READ  = 2'd0,
    BTI_CMD_WRITE = 2'd1
  } bti_cmd_e;

  typedef struct packed {
    logic [BTI_TIDW-1:0] tid;
    bti_cmd_e            cmd;
    logic [31:0]         addr;
    logic [31:0]         data;
    logic [3:0]          strobe;
  } bti_req_pkt_t;

  typedef struct packed {
    logic [BTI_TIDW-1:0] tid;
    logic [31:0]         data;
    logic                ok;
  } bti_rsp_pkt_t;

endpackage

// File: rtl/bti_tcm_if.sv
// rtl/bti_tcm_if.sv - BTI request and response channel interfaces
// Purpose: vld/rdy channels carrying BTI packets.
// Ports (per interface): vld (mst->slv), rdy (slv->mst), pkt (mst->slv).
interface bti_req_if_t;
  import bti_pkg::*;
  logic         vld;
  logic         rdy;
  bti_req_pkt_t pkt;
  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
  import bti_pkg::*;
  logic         vld;
  logic         rdy;
  bti_rsp_pkt_t pkt;
  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_rsp_fifo.sv
// rtl/bti_rsp_fifo.sv - 2-entry response FIFO with parameterised payload
// Purpose: buffers completed responses ahead of the response channel.
// Ports: clk, rst_n (sync, active-low); in_vld/in_data push side;
//        out_vld/out_data/out_rdy pop side; cnt = current occupancy (0..2).
module bti_rsp_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    out_vld  = (cnt_q != 2'd0);
    out_data = mem_q[rd_ptr_q];
    cnt      = cnt_q;
    pop      = out_vld && out_rdy;
    // The upstream credit check keeps pushes within capacity; the guard
    // only protects the storage if that contract is ever broken.
    push     = in_vld && ((cnt_q != 2'd2) || pop);
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: it is only observed when cnt_q != 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bti_tcm.sv
// rtl/bti_tcm.sv - BTI tightly-coupled memory front end
// Purpose: decodes BTI requests onto an external single-port SRAM and
// returns in-order responses through a pending stage and a 2-entry FIFO.
// Ports: clk, rst_n (sync, active-low); bti_req_slv request channel;
//        bti_rsp_mst response channel; sram_en/we/addr/wdata/wstrb to the
//        array; sram_rdata from the array, valid one cycle after a read.
module bti_tcm
  import bti_pkg::*;
#(
  parameter int          DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0001_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bti_req_if_t.slv                 bti_req_slv,
  bti_rsp_if_t.mst                 bti_rsp_mst,
  output logic                     sram_en,
  output logic                     sram_we,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [31:0]              sram_wdata,
  output logic [3:0]               sram_wstrb,
  input  logic [31:0]              sram_rdata
);

  localparam int AW   = $clog2(DEPTH);
  localparam int RSPW = $bits(bti_rsp_pkt_t);

  bti_req_pkt_t        req;
  logic [31:0]         off;
  logic                in_range, aligned, is_rd, is_wr, acc_ok, accept;
  logic                p_vld_q, p_vld_d;
  logic                p_rd_q, p_rd_d;
  logic                p_ok_q, p_ok_d;
  logic [BTI_TIDW-1:0] p_tid_q, p_tid_d;
  logic [2:0]          occ;
  logic                pop;
  logic [1:0]          fifo_cnt;
  logic                fifo_vld;
  logic [RSPW-1:0]     fifo_in, fifo_out;
  bti_rsp_pkt_t        push_pkt;

  always_comb begin
    req      = bti_req_slv.pkt;
    off      = req.addr - BASE;
    // Upper offset bits zero means the word index fits in the array.
    in_range = (req.addr >= BASE) && (off[31:AW+2] == '0);
    // BASE is word aligned, so the offset low bits equal addr[1:0].
    aligned  = (off[1:0] == 2'b00);
    is_rd    = (req.cmd == BTI_CMD_READ);
    is_wr    = (req.cmd == BTI_CMD_WRITE);
    acc_ok   = in_range && aligned && (is_rd || is_wr);

    // Every slot held by the pending stage or the FIFO is a spent credit;
    // a same-cycle pop returns one, which sustains one request per cycle.
    pop             = fifo_vld && bti_rsp_mst.rdy;
    occ             = 3'(p_vld_q) + 3'(fifo_cnt) - 3'(pop);
    bti_req_slv.rdy = rst_n && (occ < 3'd2);
    accept          = bti_req_slv.vld && bti_req_slv.rdy;

    sram_en    = accept && acc_ok;
    sram_we    = is_wr;
    sram_addr  = off[AW+1:2];
    sram_wdata = req.data;
    sram_wstrb = req.strobe;

    // The pending entry always drains into the FIFO on the next cycle; the
    // credit rule guarantees the FIFO has room for it.
    p_vld_d = accept;
    p_tid_d = accept ? req.tid : p_tid_q;
    p_rd_d  = accept && acc_ok && is_rd;
    p_ok_d  = accept && acc_ok;

    push_pkt.tid  = p_tid_q;
    push_pkt.data = p_rd_q ? sram_rdata : 32'h0;
    push_pkt.ok   = p_ok_q;
    fifo_in       = push_pkt;

    bti_rsp_mst.vld = fifo_vld;
    bti_rsp_mst.pkt = bti_rsp_pkt_t'(fifo_out);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_vld_q <= 1'b0;
      p_tid_q <= '0;
      p_rd_q  <= 1'b0;
      p_ok_q  <= 1'b0;
    end else begin
      p_vld_q <= p_vld_d;
      p_tid_q <= p_tid_d;
      p_rd_q  <= p_rd_d;
      p_ok_q  <= p_ok_d;
    end
  end

  bti_rsp_fifo #(
    .WIDTH (RSPW)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (p_vld_q),
    .in_data  (fifo_in),
    .out_vld  (fifo_vld),
    .out_data (fifo_out),
    .out_rdy  (bti_rsp_mst.rdy),
    .cnt      (fifo_cnt)
  );

endmodule

// File: tb/tb_bti_tcm.sv
// tb/tb_bti_tcm.sv - self-checking bench for bti_tcm
module tb_bti_tcm;
  import bti_pkg::*;

  localparam int          DEPTH = 4096;
  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  typedef struct {
    int           cyc;
    bti_rsp_pkt_t pkt;
  } got_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bti_req_if_t req_if ();
  bti_rsp_if_t rsp_if ();

  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [3:0]    sram_wstrb;
  logic [31:0]   sram_arr [DEPTH];

  logic tb_rsp_rdy;
  logic rand_mode;
  logic rand_rdy;
  assign rsp_if.rdy = rand_mode ? rand_rdy : tb_rsp_rdy;

  int total = 0;
  int bad   = 0;

  bti_tcm #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bti_req_slv (req_if),
    .bti_rsp_mst (rsp_if),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_wstrb  (sram_wstrb),
    .sram_rdata  (sram_rdata)
  );

  // External single-port array.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wstrb[b]) sram_arr[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_arr[sram_addr];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rand_rdy = ($urandom_range(0, 3) != 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word-addressed memory updated in acceptance order.
  logic [31:0] ref_mem [int];

  function automatic bti_rsp_pkt_t model(input bti_req_pkt_t p, output bit ok, output int idx);
    bti_rsp_pkt_t r;
    longint       a   = longint'(p.addr);
    bit           inr = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    logic [31:0]  w;
    ok    = inr && (p.addr[1:0] == 2'b00) && (p.cmd == BTI_CMD_READ || p.cmd == BTI_CMD_WRITE);
    idx   = int'((a - longint'(BASE)) / 4);
    r.tid  = p.tid;
    r.ok   = ok;
    r.data = 32'h0;
    if (ok && p.cmd == BTI_CMD_READ) r.data = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (ok && p.cmd == BTI_CMD_WRITE) begin
      w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (p.strobe[b]) w[8*b +: 8] = p.data[8*b +: 8];
      ref_mem[idx] = w;
    end
    return r;
  endfunction

  // Monitor: records accepted requests (with model expectations), observed
  // responses, and tallies array-port cycles that disagree with the model.
  bti_rsp_pkt_t exp_q[$];
  got_t         got_q[$];
  int           acc_cyc_q[$];
  int           en_cnt   = 0;
  int           sram_bad = 0;

  always @(negedge clk) begin
    bit ok;
    int idx;
    if (sram_en === 1'b1) en_cnt++;
    if (rst_n && req_if.vld && req_if.rdy) begin
      acc_cyc_q.push_back(cyc);
      exp_q.push_back(model(req_if.pkt, ok, idx));
      if (sram_en !== ok) sram_bad++;
      else if (ok && (sram_addr !== AW'(idx) || sram_we !== (req_if.pkt.cmd == BTI_CMD_WRITE))) sram_bad++;
    end else if (sram_en !== 1'b0) begin
      sram_bad++;
    end
    if (rsp_if.vld === 1'b1 && rsp_if.rdy === 1'b1) got_q.push_back('{cyc, rsp_if.pkt});
  end

  task automatic send(input logic [BTI_TIDW-1:0] tid, input bti_cmd_e cmd,
                      input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    req_if.vld = 1'b1;
    req_if.pkt = '{tid: tid, cmd: cmd, addr: addr, data: data, strobe: strb};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_if.rdy) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int g0, input int e0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() - g0 >= exp_q.size() - e0) break;
      @(posedge clk);
      #2;
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_if.vld = 1'b0; tb_rsp_rdy = 1'b1; rand_mode = 1'b0;
    req_if.pkt = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (rsp_if.vld !== 1'b0) begin bad++; $display("FAIL reset_rsp_vld got=%b exp=0", rsp_if.vld); end
    total++; if (req_if.rdy !== 1'b1) begin bad++; $display("FAIL reset_req_rdy got=%b exp=1", req_if.rdy); end
    total++; if (sram_en !== 1'b0) begin bad++; $display("FAIL reset_sram_en got=%b exp=0", sram_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int g0 = got_q.size(), e0 = exp_q.size(), en0 = en_cnt, n;
    bti_rsp_pkt_t k;
    send(4'd1, BTI_CMD_WRITE, 32'h0001_0004, 32'hDEADBEEF, 4'hF);
    send(4'd2, BTI_CMD_READ,  32'h0001_0004, 32'h0, 4'h0);
    send(4'd3, BTI_CMD_WRITE, 32'h0001_0004, 32'h11223344, 4'b0101);
    send(4'd4, BTI_CMD_READ,  32'h0001_0004, 32'h0, 4'h0);
    send(4'd5, BTI_CMD_WRITE, 32'h0001_0004, 32'hFFFFFFFF, 4'b0000);
    send(4'd6, BTI_CMD_READ,  32'h0001_0004, 32'h0, 4'h0);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    n = got_q.size() - g0;
    total++; if (n != 6) begin bad++; $display("FAIL wr_rd_count got=%0d exp=6", n); end
    if (n >= 6) begin
      k = '{tid: 4'd2, data: 32'hDEADBEEF, ok: 1'b1};
      total++; if (got_q[g0+1].pkt !== k) begin bad++; $display("FAIL wr_rd_full got=%h exp=%h", got_q[g0+1].pkt, k); end
      k = '{tid: 4'd4, data: 32'hDE22BE44, ok: 1'b1};
      total++; if (got_q[g0+3].pkt !== k) begin bad++; $display("FAIL wr_rd_strobe got=%h exp=%h", got_q[g0+3].pkt, k); end
      k = '{tid: 4'd5, data: 32'h0, ok: 1'b1};
      total++; if (got_q[g0+4].pkt !== k) begin bad++; $display("FAIL wr_zero_strb_rsp got=%h exp=%h", got_q[g0+4].pkt, k); end
      k = '{tid: 4'd6, data: 32'hDE22BE44, ok: 1'b1};
      total++; if (got_q[g0+5].pkt !== k) begin bad++; $display("FAIL wr_zero_strb_rd got=%h exp=%h", got_q[g0+5].pkt, k); end
    end
    total++; if (en_cnt - en0 != 6) begin bad++; $display("FAIL wr_rd_en_cycles got=%0d exp=6", en_cnt - en0); end
  endtask

  task automatic test_errors();
    int g0 = got_q.size(), e0 = exp_q.size(), en0 = en_cnt, n;
    send(4'd7,  BTI_CMD_READ, 32'h0000_FFFC, 32'h0, 4'h0);
    send(4'd8,  BTI_CMD_READ, 32'h0001_0002, 32'h0, 4'h0);
    send(4'd9,  BTI_CMD_READ, BASE + 32'(4 * DEPTH), 32'h0, 4'h0);
    send(4'd10, bti_cmd_e'(2'd3), 32'h0001_0008, 32'h12345678, 4'hF);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    n = got_q.size() - g0;
    total++; if (n != 4) begin bad++; $display("FAIL err_count got=%0d exp=4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      total++;
      if (got_q[g0+i].pkt.ok !== 1'b0 || got_q[g0+i].pkt.data !== 32'h0 || got_q[g0+i].pkt.tid !== 4'(7 + i)) begin
        bad++; $display("FAIL err_rsp[%0d] got=%h exp_tid=%0d ok=0 data=0", i, got_q[g0+i].pkt, 7 + i);
      end
    end
    total++; if (en_cnt != en0) begin bad++; $display("FAIL err_sram_en got=%0d exp=0", en_cnt - en0); end
    // Last in-range word.
    g0 = got_q.size(); e0 = exp_q.size();
    send(4'd11, BTI_CMD_WRITE, BASE + 32'(4 * DEPTH - 4), 32'hA5A5_5A5A, 4'hF);
    send(4'd12, BTI_CMD_READ,  BASE + 32'(4 * DEPTH - 4), 32'h0, 4'h0);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    total++;
    if (got_q.size() - g0 != 2 || got_q[got_q.size()-1].pkt !== bti_rsp_pkt_t'{tid: 4'd12, data: 32'hA5A5_5A5A, ok: 1'b1}) begin
      bad++; $display("FAIL err_last_word got_n=%0d exp_n=2 data=a5a55a5a", got_q.size() - g0);
    end
  endtask

  task automatic test_back_to_back();
    int g0 = got_q.size(), e0 = exp_q.size(), a0, n;
    for (int i = 0; i < 16; i++) send(4'(i), BTI_CMD_WRITE, BASE + 32'(4 * i), $urandom, 4'hF);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    g0 = got_q.size(); e0 = exp_q.size(); a0 = acc_cyc_q.size();
    for (int i = 0; i < 16; i++) send(4'(i), BTI_CMD_READ, BASE + 32'(4 * i), 32'h0, 4'h0);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    n = got_q.size() - g0;
    total++; if (n != 16) begin bad++; $display("FAIL b2b_count got=%0d exp=16", n); end
    for (int i = 0; i < n && i < 16; i++) begin
      total++;
      if (got_q[g0+i].pkt !== exp_q[e0+i] || got_q[g0+i].pkt.tid !== 4'(i)) begin
        bad++; $display("FAIL b2b_rsp[%0d] got=%h exp=%h", i, got_q[g0+i].pkt, exp_q[e0+i]);
      end
      total++;
      if (got_q[g0+i].cyc != acc_cyc_q[a0] + 2 + i) begin
        bad++; $display("FAIL b2b_timing[%0d] got_cyc=%0d exp_cyc=%0d", i, got_q[g0+i].cyc, acc_cyc_q[a0] + 2 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    int g0 = got_q.size(), e0 = exp_q.size(), a0 = acc_cyc_q.size(), k = 0, n;
    logic h;
    tb_rsp_rdy = 1'b0;
    req_if.vld = 1'b1;
    req_if.pkt = '{tid: 4'(k), cmd: BTI_CMD_READ, addr: BASE + 32'(4 * k), data: 32'h0, strobe: 4'h0};
    repeat (5) begin
      @(negedge clk); h = req_if.rdy;
      @(posedge clk); #1;
      if (h) begin
        k++;
        req_if.pkt = '{tid: 4'(k), cmd: BTI_CMD_READ, addr: BASE + 32'(4 * k), data: 32'h0, strobe: 4'h0};
      end
    end
    @(negedge clk);
    total++; if (acc_cyc_q.size() - a0 != 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", acc_cyc_q.size() - a0); end
    total++; if (req_if.rdy !== 1'b0) begin bad++; $display("FAIL bp_req_rdy got=%b exp=0", req_if.rdy); end
    @(posedge clk); #1;
    tb_rsp_rdy = 1'b1;
    for (int i = k; i < 5; i++) send(4'(i), BTI_CMD_READ, BASE + 32'(4 * i), 32'h0, 4'h0);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    n = got_q.size() - g0;
    total++; if (n != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", n); end
    for (int i = 0; i < n && i < 5; i++) begin
      total++;
      if (got_q[g0+i].pkt !== exp_q[e0+i]) begin bad++; $display("FAIL bp_rsp[%0d] got=%h exp=%h", i, got_q[g0+i].pkt, exp_q[e0+i]); end
    end
  endtask

  task automatic test_reset_mid();
    int g0 = got_q.size(), e0 = exp_q.size();
    bti_rsp_pkt_t k;
    send(4'd1, BTI_CMD_WRITE, BASE + 32'd20, 32'h0BAD_F00D, 4'hF);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    tb_rsp_rdy = 1'b0;
    send(4'd2, BTI_CMD_READ, BASE + 32'd20, 32'h0, 4'h0);
    send(4'd3, BTI_CMD_READ, BASE + 32'd24, 32'h0, 4'h0);
    req_if.vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (rsp_if.vld !== 1'b1 || req_if.rdy !== 1'b0) begin bad++; $display("FAIL rstmid_full got_vld=%b got_rdy=%b exp=1/0", rsp_if.vld, req_if.rdy); end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; tb_rsp_rdy = 1'b1;
    @(negedge clk);
    total++; if (rsp_if.vld !== 1'b0) begin bad++; $display("FAIL rstmid_rsp_vld got=%b exp=0", rsp_if.vld); end
    total++; if (req_if.rdy !== 1'b1) begin bad++; $display("FAIL rstmid_req_rdy got=%b exp=1", req_if.rdy); end
    g0 = got_q.size(); e0 = exp_q.size();
    repeat (8) @(posedge clk); #2;
    total++; if (got_q.size() != g0) begin bad++; $display("FAIL rstmid_discard got=%0d exp=0", got_q.size() - g0); end
    send(4'd4, BTI_CMD_READ, BASE + 32'd20, 32'h0, 4'h0);
    req_if.vld = 1'b0;
    wait_drain(g0, e0, 100);
    k = '{tid: 4'd4, data: 32'h0BAD_F00D, ok: 1'b1};
    total++;
    if (got_q.size() - g0 != 1 || got_q[got_q.size()-1].pkt !== k) begin
      bad++; $display("FAIL rstmid_retained got_n=%0d exp=%h", got_q.size() - g0, k);
    end
  endtask

  task automatic test_random();
    int g0 = got_q.size(), e0 = exp_q.size(), n, w, r, bad0 = bad;
    logic [31:0] a;
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : int'($urandom_range(0, 15));
      a = BASE + 32'(4 * w);
      r = int'($urandom_range(0, 9));
      if (r <= 4) send(4'($urandom), BTI_CMD_READ, a, 32'h0, 4'h0);
      else if (r <= 7) send(4'($urandom), BTI_CMD_WRITE, a, $urandom, 4'($urandom));
      else if (r == 8) begin
        case ($urandom_range(0, 3))
          0: a = a + 32'($urandom_range(1, 3));
          1: a = BASE - 32'd4;
          2: a = BASE + 32'(4 * DEPTH);
          default: a = 32'hFFFF_FFFC;
        endcase
        send(4'($urandom), BTI_CMD_READ, a, 32'h0, 4'h0);
      end else send(4'($urandom), bti_cmd_e'(2'($urandom_range(2, 3))), a, $urandom, 4'hF);
      if ($urandom_range(0, 3) == 0) begin
        req_if.vld = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    req_if.vld = 1'b0;
    rand_mode = 1'b0;
    wait_drain(g0, e0, 2000);
    n = got_q.size() - g0;
    total++; if (n != 300) begin bad++; $display("FAIL rand_count got=%0d exp=300", n); end
    for (int i = 0; i < n && i < exp_q.size() - e0; i++) begin
      total++;
      if (got_q[g0+i].pkt !== exp_q[e0+i]) begin
        bad++;
        if (bad - bad0 < 10) $display("FAIL rand_rsp[%0d] got=%h exp=%h", i, got_q[g0+i].pkt, exp_q[e0+i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    total++; if (sram_bad != 0) begin bad++; $display("FAIL sram_port got=%0d exp=0", sram_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
